// File: rtl/letc_mem_arbiter.sv
// letc_mem_arbiter: shares the single SoC memory port between instruction fetch (port 0) and
// data (port 1). Round-robin grant, one outstanding transaction, optional response timeout.
module letc_mem_arbiter #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [1:0]               req_valid,
   output logic [1:0]               req_ready,
   input  logic [1:0][ADDR_W-1:0]   req_addr,
   input  logic [1:0]               req_write,
   input  logic [1:0][DATA_W-1:0]   req_wdata,
   input  logic [1:0][DATA_W/8-1:0] req_wstrb,
   output logic [1:0]               rsp_valid,
   output logic [DATA_W-1:0]        rsp_rdata,
   output logic                     rsp_err,
   output logic                     mem_req_valid,
   input  logic                     mem_req_ready,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic                     mem_write,
   output logic [DATA_W-1:0]        mem_wdata,
   output logic [DATA_W/8-1:0]      mem_wstrb,
   input  logic                     mem_rsp_valid,
   input  logic [DATA_W-1:0]        mem_rsp_rdata,
   input  logic                     mem_rsp_err,
   output logic                     busy
);

   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam bit          TIMEOUT_EN = (TIMEOUT_CYC != 0);
   // Last WAIT cycle index before the timeout fires; unused when the timeout is disabled.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } state_e;

   state_e              state_q, state_d;
   logic                last_grant_q, last_grant_d;
   logic                grant_q, grant_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                write_q, write_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                pick;

   // Round-robin pick: a lone requester wins, a tie goes to the port not served last.
   always_comb begin
      pick = 1'b0;
      case (req_valid)
         2'b01:   pick = 1'b0;
         2'b10:   pick = 1'b1;
         2'b11:   pick = ~last_grant_q;
         default: pick = 1'b0;
      endcase
   end

   // Next-state logic and the combinational request acceptance.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      addr_d       = addr_q;
      write_d      = write_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      cnt_d        = cnt_q;
      req_ready    = '0;

      unique case (state_q)
         StIdle: begin
            // Nothing is accepted while reset is held, so a grant can never be lost.
            if ((|req_valid) && !rst) begin
               req_ready[pick] = 1'b1;
               grant_d         = pick;
               last_grant_d    = pick;
               addr_d          = req_addr[pick];
               write_d         = req_write[pick];
               wdata_d         = req_wdata[pick];
               wstrb_d         = req_wstrb[pick];
               state_d         = StIssue;
            end
         end
         StIssue: begin
            if (mem_req_ready) begin
               if (mem_rsp_valid) begin
                  rdata_d = mem_rsp_rdata;
                  err_d   = mem_rsp_err;
                  state_d = StResp;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            cnt_d = cnt_q + 1'b1;
            if (mem_rsp_valid) begin
               rdata_d = mem_rsp_rdata;
               err_d   = mem_rsp_err;
               state_d = StResp;
            end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = StResp;
            end
         end
         StResp: begin
            cnt_d   = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         addr_q       <= '0;
         write_q      <= 1'b0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         rdata_q      <= '0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         addr_q       <= addr_d;
         write_q      <= write_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
      end
   end

   // Response pulse steered to the port that owns the transaction.
   always_comb begin
      rsp_valid = '0;
      if (state_q == StResp) begin
         rsp_valid[grant_q] = 1'b1;
      end
   end

   assign rsp_rdata     = rdata_q;
   assign rsp_err       = err_q;
   assign mem_req_valid = (state_q == StIssue);
   assign mem_addr      = addr_q;
   assign mem_write     = write_q;
   assign mem_wdata     = wdata_q;
   assign mem_wstrb     = wstrb_q;
   assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_letc_mem_arbiter.sv
// Bench for letc_mem_arbiter: scoreboard of expected responses, a scriptable memory responder,
// and one task per scenario.
module tb_letc_mem_arbiter;

   localparam int TO = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic [1:0]       req_valid, req_ready, req_write, rsp_valid;
   logic [1:0][31:0] req_addr, req_wdata;
   logic [1:0][3:0]  req_wstrb;
   logic [31:0]      rsp_rdata, mem_addr, mem_wdata, mem_rsp_rdata;
   logic             rsp_err, mem_req_valid, mem_req_ready, mem_write;
   logic             mem_rsp_valid, mem_rsp_err, busy;
   logic [3:0]       mem_wstrb;

   letc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
      .mem_rsp_err(mem_rsp_err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  port;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   typedef struct packed {
      logic port;
      int   cyc;
   } grant_t;

   exp_t   exp_q[$];
   grant_t grant_log[$];
   int     checks = 0, errors = 0, cyc = 0, rsp_count = 0;
   int     rsp_cyc[2];

   // Memory responder controls and observations.
   int          mem_ready_delay = 0, mem_rsp_delay = 1;
   bit          mem_silent = 0, mem_fixed_en = 0, mem_err_cfg = 0, inject = 0;
   logic [31:0] mem_fixed_data = 32'h0;
   int          hs_count = 0, hs_cyc = 0;
   logic [31:0] hs_addr, hs_wdata;
   logic [3:0]  hs_wstrb;
   logic        hs_write;
   int          rs_wait = 0, rs_pend_cnt = 0;
   bit          rs_pend = 0;
   logic [31:0] rs_pend_data;
   logic        rs_pend_err;
   logic [31:0] rs_data;

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      return a ^ 32'hA5A5_5A5A;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: configurable accept delay, response delay, silence and stray injection.
   initial begin : responder
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = '0;
      mem_rsp_err   = 1'b0;
      forever begin
         @(negedge clk);
         mem_req_ready = 1'b0;
         mem_rsp_valid = 1'b0;
         mem_rsp_rdata = '0;
         mem_rsp_err   = 1'b0;
         if (inject) begin
            inject        = 0;
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = 32'hBAD0_BAD0;
         end else if (rs_pend) begin
            if (rs_pend_cnt == 0) begin
               rs_pend       = 0;
               mem_rsp_valid = 1'b1;
               mem_rsp_rdata = rs_pend_data;
               mem_rsp_err   = rs_pend_err;
            end else begin
               rs_pend_cnt--;
            end
         end
         if (!mem_req_valid) begin
            rs_wait = 0;
         end else if (!rs_pend && !mem_rsp_valid) begin
            if (rs_wait < mem_ready_delay) begin
               rs_wait++;
            end else begin
               rs_wait       = 0;
               mem_req_ready = 1'b1;
               hs_count++;
               hs_cyc   = cyc;
               hs_addr  = mem_addr;
               hs_write = mem_write;
               hs_wdata = mem_wdata;
               hs_wstrb = mem_wstrb;
               rs_data  = mem_fixed_en ? mem_fixed_data : mem_model(mem_addr);
               if (!mem_silent) begin
                  if (mem_rsp_delay == 0) begin
                     mem_rsp_valid = 1'b1;
                     mem_rsp_rdata = rs_data;
                     mem_rsp_err   = mem_err_cfg;
                  end else begin
                     rs_pend      = 1;
                     rs_pend_cnt  = mem_rsp_delay - 1;
                     rs_pend_data = rs_data;
                     rs_pend_err  = mem_err_cfg;
                  end
               end
            end
         end
      end
   end

   // Scoreboard: pops one expectation per response pulse; also logs grants.
   initial begin : monitor
      exp_t   e;
      grant_t g;
      forever begin
         @(negedge clk);
         #2;
         checks++;
         if (req_ready == 2'b11) begin
            errors++;
            $display("FAIL req_ready_onehot: got %b, required at most one bit set", req_ready);
         end
         if (req_ready != 2'b00) begin
            g.port = req_ready[1];
            g.cyc  = cyc;
            grant_log.push_back(g);
         end
         if (rsp_valid != 2'b00) begin
            rsp_count++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_rsp: got rsp_valid=%b rdata=%h err=%b, required none",
                        rsp_valid, rsp_rdata, rsp_err);
            end else begin
               e = exp_q.pop_front();
               if (rsp_valid !== e.port || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
                  errors++;
                  $display("FAIL rsp_data: got valid=%b rdata=%h err=%b, required %b %h %b",
                           rsp_valid, rsp_rdata, rsp_err, e.port, e.rdata, e.err);
               end
               rsp_cyc[rsp_valid[1]] = cyc;
            end
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish, required finish within 30000 cycles");
      $fatal(1, "watchdog expired");
   end

   // Port 0 issues reads at base0, port 1 writes at base1; each re-requests right after accept.
   task automatic drive_ports(input int n0, input int n1, input logic [31:0] base0,
                              input logic [31:0] base1, input logic [31:0] wdata1,
                              input logic [3:0] wstrb1, output bit ok);
      int left0, left1, k0, k1;
      left0 = n0;
      left1 = n1;
      k0    = 0;
      k1    = 0;
      ok    = 0;
      for (int c = 0; c < 200 && !ok; c++) begin
         @(negedge clk);
         req_valid    = {left1 > 0, left0 > 0};
         req_addr[0]  = base0 + 32'(4 * k0);
         req_write[0] = 1'b0;
         req_wdata[0] = 32'h0;
         req_wstrb[0] = 4'hF;
         req_addr[1]  = base1 + 32'(4 * k1);
         req_write[1] = 1'b1;
         req_wdata[1] = wdata1 + 32'(k1);
         req_wstrb[1] = wstrb1;
         #1;
         if (left0 == 0 && left1 == 0) begin
            ok = 1;
         end else begin
            if (req_ready[0]) begin left0--; k0++; end
            if (req_ready[1]) begin left1--; k1++; end
         end
      end
      if (!ok) req_valid = 2'b00;
   endtask

   task automatic test_reset;
      rst       = 1'b1;
      req_valid = 2'b00;
      req_addr  = '0;
      req_write = 2'b00;
      req_wdata = '0;
      req_wstrb = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if ({busy, mem_req_valid, mem_write, rsp_err, rsp_valid, req_ready} !== 8'h00) begin
         errors++;
         $display("FAIL reset_ctrl: got busy=%b mrv=%b mw=%b err=%b rv=%b rr=%b, required all 0",
                  busy, mem_req_valid, mem_write, rsp_err, rsp_valid, req_ready);
      end
      checks++;
      if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0
          || rsp_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: got addr=%h wdata=%h wstrb=%h rdata=%h, required all 0",
                  mem_addr, mem_wdata, mem_wstrb, rsp_rdata);
      end
   endtask

   task automatic test_tie_after_reset;
      bit ok;
      mem_ready_delay = 0;
      mem_rsp_delay   = 1;
      grant_log.delete();
      exp_q.push_back('{port: 2'b01, rdata: mem_model(32'h1000), err: 1'b0});
      exp_q.push_back('{port: 2'b10, rdata: mem_model(32'h2000), err: 1'b0});
      drive_ports(1, 1, 32'h1000, 32'h2000, 32'h1111_0000, 4'hF, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL tie_accept: got no accept, required 2"); end
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL tie_drain: got %0d outstanding, required 0", exp_q.size());
      end
      checks++;
      if (grant_log.size() != 2 || grant_log[0].port !== 1'b0
          || grant_log[1].cyc != rsp_cyc[0] + 1) begin
         errors++;
         $display("FAIL tie_order: got %0d grants, second at cycle %0d, required port1 at %0d",
                  grant_log.size(), (grant_log.size() > 1) ? grant_log[1].cyc : -1,
                  rsp_cyc[0] + 1);
      end
   endtask

   task automatic test_round_robin;
      bit ok;
      grant_log.delete();
      exp_q.push_back('{port: 2'b01, rdata: mem_model(32'h3000), err: 1'b0});
      exp_q.push_back('{port: 2'b10, rdata: mem_model(32'h4000), err: 1'b0});
      exp_q.push_back('{port: 2'b01, rdata: mem_model(32'h3004), err: 1'b0});
      exp_q.push_back('{port: 2'b10, rdata: mem_model(32'h4004), err: 1'b0});
      drive_ports(2, 2, 32'h3000, 32'h4000, 32'h2222_0000, 4'hF, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rr_accept: got stalled, required 4 accepts"); end
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rr_drain: got %0d outstanding, required 0", exp_q.size());
      end
      checks++;
      if (grant_log.size() != 4 || grant_log[0].port !== 1'b0 || grant_log[1].port !== 1'b1
          || grant_log[2].port !== 1'b0 || grant_log[3].port !== 1'b1) begin
         errors++;
         $display("FAIL rr_order: got %0d grants, required order 0,1,0,1", grant_log.size());
      end
   endtask

   task automatic test_backpressure;
      bit ok;
      int vcnt, bad, hs0;
      mem_ready_delay = 5;
      mem_rsp_delay   = 2;
      mem_err_cfg     = 1;
      hs0             = hs_count;
      exp_q.push_back('{port: 2'b10, rdata: mem_model(32'h5000), err: 1'b1});
      drive_ports(0, 1, 32'h0, 32'h5000, 32'hDEAD_BEEF, 4'b0011, ok);
      vcnt = 0;
      bad  = 0;
      for (int i = 0; i < 20; i++) begin
         if (mem_req_valid) begin
            vcnt++;
            if (mem_addr !== 32'h5000 || mem_write !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF
                || mem_wstrb !== 4'b0011) bad++;
         end
         @(negedge clk);
         #1;
      end
      checks++;
      if (vcnt != 6 || bad != 0 || !ok) begin
         errors++;
         $display("FAIL bp_hold: got %0d valid cycles, %0d unstable, required 6 and 0", vcnt, bad);
      end
      checks++;
      if (hs_count - hs0 != 1 || hs_wdata !== 32'hDEAD_BEEF || hs_wstrb !== 4'b0011
          || hs_write !== 1'b1) begin
         errors++;
         $display("FAIL bp_handshake: got %0d handshakes wdata=%h wstrb=%b, required 1 deadbeef 0011",
                  hs_count - hs0, hs_wdata, hs_wstrb);
      end
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL bp_drain: got %0d outstanding, required 0", exp_q.size());
      end
      mem_ready_delay = 0;
      mem_err_cfg     = 0;
   endtask

   task automatic test_same_cycle;
      bit ok;
      mem_rsp_delay  = 0;
      mem_fixed_en   = 1;
      mem_fixed_data = 32'h1234_5678;
      grant_log.delete();
      exp_q.push_back('{port: 2'b01, rdata: 32'h1234_5678, err: 1'b0});
      drive_ports(1, 0, 32'h6000, 32'h0, 32'h0, 4'hF, ok);
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0 || !ok) begin
         errors++;
         $display("FAIL same_drain: got %0d outstanding, required 0", exp_q.size());
      end
      checks++;
      if (grant_log.size() != 1 || hs_cyc != grant_log[0].cyc + 1
          || rsp_cyc[0] != grant_log[0].cyc + 2) begin
         errors++;
         $display("FAIL same_latency: got hs at +%0d rsp at +%0d, required +1 and +2",
                  hs_cyc - ((grant_log.size() > 0) ? grant_log[0].cyc : 0),
                  rsp_cyc[0] - ((grant_log.size() > 0) ? grant_log[0].cyc : 0));
      end
      mem_fixed_en  = 0;
      mem_rsp_delay = 1;
   endtask

   task automatic test_timeout;
      bit ok;
      int rc0;
      mem_silent = 1;
      exp_q.push_back('{port: 2'b01, rdata: 32'h0, err: 1'b1});
      drive_ports(1, 0, 32'h7000, 32'h0, 32'h0, 4'hF, ok);
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0 || !ok) begin
         errors++;
         $display("FAIL to_drain: got %0d outstanding, required 0", exp_q.size());
      end
      checks++;
      if (rsp_cyc[0] - hs_cyc != TO + 1) begin
         errors++;
         $display("FAIL to_latency: got rsp %0d cycles after handshake, required %0d",
                  rsp_cyc[0] - hs_cyc, TO + 1);
      end
      rc0 = rsp_count;
      repeat (2) @(negedge clk);
      inject = 1;
      repeat (6) @(negedge clk);
      checks++;
      if (rsp_count != rc0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL to_late_rsp: got %0d extra pulses busy=%b, required 0 and 0",
                  rsp_count - rc0, busy);
      end
      mem_silent = 0;
   endtask

   task automatic test_reset_mid;
      bit ok;
      int rc0;
      mem_rsp_delay = 5;
      rc0           = rsp_count;
      drive_ports(1, 0, 32'h8000, 32'h0, 32'h0, 4'hF, ok);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b1 || mem_req_valid !== 1'b0 || !ok) begin
         errors++;
         $display("FAIL rm_in_wait: got busy=%b mrv=%b, required 1 and 0", busy, mem_req_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if ({busy, mem_req_valid, mem_write, rsp_err, rsp_valid, req_ready} !== 8'h00
          || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0
          || rsp_rdata !== 32'h0) begin
         errors++;
         $display("FAIL rm_outputs: got busy=%b err=%b addr=%h rdata=%h, required all 0",
                  busy, rsp_err, mem_addr, rsp_rdata);
      end
      repeat (8) @(negedge clk);
      checks++;
      if (rsp_count != rc0) begin
         errors++;
         $display("FAIL rm_no_rsp: got %0d pulses, required 0", rsp_count - rc0);
      end
      mem_rsp_delay = 1;
      grant_log.delete();
      exp_q.push_back('{port: 2'b01, rdata: mem_model(32'h9000), err: 1'b0});
      exp_q.push_back('{port: 2'b10, rdata: mem_model(32'hA000), err: 1'b0});
      drive_ports(1, 1, 32'h9000, 32'hA000, 32'h3333_0000, 4'hF, ok);
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0 || grant_log.size() == 0 || grant_log[0].port !== 1'b0) begin
         errors++;
         $display("FAIL rm_tie: got %0d outstanding, first grant port %0d, required 0 and 0",
                  exp_q.size(), (grant_log.size() > 0) ? int'(grant_log[0].port) : -1);
      end
   endtask

   initial begin
      test_reset();
      test_tie_after_reset();
      test_round_robin();
      test_backpressure();
      test_same_cycle();
      test_timeout();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
